// File: rtl/uart_prog_loader.sv
// UART 8N1 program-image loader: assembles little-endian bytes into 32-bit words for imem and
// holds the core in reset until the image is complete. Optional trailing checksum: LOADER_CHECKSUM_EN.
module uart_prog_loader #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned IMEM_DEPTH   = 256,
  parameter int unsigned ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [31:0]       instruction,
  output logic              en,
  output logic [ADDR_W-1:0] addr,
  output logic              core_rst,
  output logic              done,
  output logic              error
);

  localparam int unsigned      CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [15:0]      DEPTH16 = 16'(IMEM_DEPTH);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {LD_LEN_LO, LD_LEN_HI, LD_DATA, LD_CHK, LD_DONE, LD_ERR} ld_state_e;
`else
  typedef enum logic [2:0] {LD_LEN_LO, LD_LEN_HI, LD_DATA, LD_DONE, LD_ERR} ld_state_e;
`endif

  logic             rx_meta_q, rx_sync_q;
  rx_state_e        rx_state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       rx_byte_q;
  logic             byte_valid_q, frame_err_q;

  ld_state_e        ld_state_q;
  logic [7:0]       len_lo_q;
  logic [15:0]      n_q, widx_q;
  logic [1:0]       bcnt_q;
  logic [23:0]      shift_q;
  logic [31:0]      instruction_q;
  logic             en_q, core_rst_q, done_q, error_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]      len_c;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]       xor_q;
`endif

  assign len_c       = {rx_byte_q, len_lo_q};
  assign instruction = instruction_q;
  assign en          = en_q;
  assign addr        = addr_q;
  assign core_rst    = core_rst_q;
  assign done        = done_q;
  assign error       = error_q;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Byte receiver: mid-bit sampling, start-bit glitch rejection, stop-bit framing check.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state_q   <= RX_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      rx_byte_q    <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          cnt_q <= '0;
          if (!rx_sync_q) rx_state_q <= RX_START;
        end
        RX_START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q      <= '0;
            bit_q      <= '0;
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_q     <= '0;
            rx_byte_q <= {rx_sync_q, rx_byte_q[7:1]};
            bit_q     <= bit_q + 3'd1;
            if (bit_q == 3'd7) rx_state_q <= RX_STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_q        <= '0;
            byte_valid_q <= rx_sync_q;
            frame_err_q  <= ~rx_sync_q;
            rx_state_q   <= RX_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // Load sequencer: length header, word assembly and strobe, optional checksum, terminal states.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_state_q    <= LD_LEN_LO;
      len_lo_q      <= '0;
      n_q           <= '0;
      widx_q        <= '0;
      bcnt_q        <= '0;
      shift_q       <= '0;
      instruction_q <= '0;
      en_q          <= 1'b0;
      addr_q        <= '0;
      core_rst_q    <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      xor_q         <= '0;
`endif
    end else begin
      en_q <= 1'b0;
      if (frame_err_q && ld_state_q != LD_DONE && ld_state_q != LD_ERR) begin
        error_q    <= 1'b1;
        ld_state_q <= LD_ERR;
      end else if (byte_valid_q) begin
        case (ld_state_q)
          LD_LEN_LO: begin
            len_lo_q   <= rx_byte_q;
            ld_state_q <= LD_LEN_HI;
          end
          LD_LEN_HI: begin
            if (len_c == 16'd0) begin
              done_q     <= 1'b1;
              core_rst_q <= 1'b1;
              ld_state_q <= LD_DONE;
            end else if (len_c > DEPTH16) begin
              error_q    <= 1'b1;
              ld_state_q <= LD_ERR;
            end else begin
              n_q        <= len_c;
              widx_q     <= '0;
              bcnt_q     <= '0;
              ld_state_q <= LD_DATA;
            end
          end
          LD_DATA: begin
            bcnt_q <= bcnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            xor_q  <= xor_q ^ rx_byte_q;
`endif
            if (bcnt_q == 2'd3) begin
              instruction_q <= {rx_byte_q, shift_q};
              en_q          <= 1'b1;
              addr_q        <= ADDR_W'(widx_q);
              widx_q        <= widx_q + 16'd1;
              if (widx_q == n_q - 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
                ld_state_q <= LD_CHK;
`else
                done_q     <= 1'b1;
                core_rst_q <= 1'b1;
                ld_state_q <= LD_DONE;
`endif
              end
            end else begin
              shift_q <= {rx_byte_q, shift_q[23:8]};
            end
          end
`ifdef LOADER_CHECKSUM_EN
          LD_CHK: begin
            if (rx_byte_q == xor_q) begin
              done_q     <= 1'b1;
              core_rst_q <= 1'b1;
              ld_state_q <= LD_DONE;
            end else begin
              error_q    <= 1'b1;
              ld_state_q <= LD_ERR;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader: directed vectors plus randomized images against a
// byte-stream reference model; follows LOADER_CHECKSUM_EN when it is defined.
module tb_uart_prog_loader;

  localparam int unsigned CPB   = 8;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx  = 1'b1;
  logic [31:0]   instruction;
  logic          en;
  logic [AW-1:0] addr;
  logic          core_rst, done, error;

  int total = 0;
  int bad   = 0;

  logic [7:0]  img[$];
  logic [39:0] got_q[$];
  logic [39:0] exp_q[$];
  logic        exp_done, exp_err;

  always #5 clk = ~clk;

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .IMEM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .rx(rx), .instruction(instruction), .en(en), .addr(addr),
    .core_rst(core_rst), .done(done), .error(error)
  );

  // Record every write strobe as {addr, instruction}.
  always @(negedge clk) if (rst && en) got_q.push_back({addr, instruction});

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    @(negedge clk); rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = bad_stop ? 1'b0 : 1'b1;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_image(input int bad_idx);
    for (int i = 0; i < img.size(); i++) send_byte(img[i], i == bad_idx);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b0; rx = 1'b1;
    repeat (3) @(negedge clk);
    got_q.delete();
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic add_chk();
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    for (int i = 2; i < img.size(); i++) x ^= img[i];
    img.push_back(x);
`endif
  endtask

  // Reference: walk the byte stream by the loader's rules; bad_idx marks a framing-error byte.
  task automatic model(input int bad_idx);
    int n, p;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
`endif
    exp_q.delete(); exp_done = 1'b0; exp_err = 1'b0;
    if (bad_idx == 0 || bad_idx == 1) begin exp_err = 1'b1; return; end
    n = int'({img[1], img[0]});
    if (n == 0) begin exp_done = 1'b1; return; end
    if (n > int'(DEPTH)) begin exp_err = 1'b1; return; end
    for (int w = 0; w < n; w++) begin
      p = 2 + 4 * w;
      if (bad_idx >= p && bad_idx < p + 4) begin exp_err = 1'b1; return; end
      exp_q.push_back({8'(w), img[p+3], img[p+2], img[p+1], img[p]});
`ifdef LOADER_CHECKSUM_EN
      x ^= img[p] ^ img[p+1] ^ img[p+2] ^ img[p+3];
`endif
    end
`ifdef LOADER_CHECKSUM_EN
    p = 2 + 4 * n;
    if (bad_idx == p || img[p] != x) exp_err = 1'b1;
    else exp_done = 1'b1;
`else
    exp_done = 1'b1;
`endif
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b0; rx = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (instruction !== 32'h0) begin bad++; $display("FAIL reset.instruction got %h want 0", instruction); end
    total++; if (en !== 1'b0)           begin bad++; $display("FAIL reset.en got %b want 0", en); end
    total++; if (addr !== '0)           begin bad++; $display("FAIL reset.addr got %h want 0", addr); end
    total++; if (core_rst !== 1'b0)     begin bad++; $display("FAIL reset.core_rst got %b want 0", core_rst); end
    total++; if (done !== 1'b0)         begin bad++; $display("FAIL reset.done got %b want 0", done); end
    total++; if (error !== 1'b0)        begin bad++; $display("FAIL reset.error got %b want 0", error); end
    rst = 1'b1;
    repeat (20) @(negedge clk);
    total++; if (core_rst !== 1'b0)     begin bad++; $display("FAIL reset.idle_core_rst got %b want 0", core_rst); end
  endtask

  task automatic test_two_words();
    logic [39:0] want[2];
    want[0] = {8'h00, 32'h0000_0013};
    want[1] = {8'h01, 32'h0031_00B3};
    do_reset();
    img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h31, 8'h00};
    add_chk();
    send_image(-1);
    total++; if (got_q.size() != 2) begin bad++; $display("FAIL two_words.count got %0d want 2", got_q.size()); end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (i >= got_q.size()) begin bad++; $display("FAIL two_words.w%0d got none want %h", i, want[i]); end
      else if (got_q[i] !== want[i]) begin bad++; $display("FAIL two_words.w%0d got %h want %h", i, got_q[i], want[i]); end
    end
    total++; if (done !== 1'b1)     begin bad++; $display("FAIL two_words.done got %b want 1", done); end
    total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL two_words.core_rst got %b want 1", core_rst); end
    total++; if (error !== 1'b0)    begin bad++; $display("FAIL two_words.error got %b want 0", error); end
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    total++; if (got_q.size() != 2) begin bad++; $display("FAIL two_words.after_done_count got %0d want 2", got_q.size()); end
  endtask

  task automatic test_zero_len();
    do_reset();
    img = '{8'h00, 8'h00};
    send_image(-1);
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL zero_len.count got %0d want 0", got_q.size()); end
    total++; if (done !== 1'b1)     begin bad++; $display("FAIL zero_len.done got %b want 1", done); end
    total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL zero_len.core_rst got %b want 1", core_rst); end
    total++; if (error !== 1'b0)    begin bad++; $display("FAIL zero_len.error got %b want 0", error); end
  endtask

  task automatic test_too_long();
    do_reset();
    img = '{8'h01, 8'h01, 8'h13, 8'h00, 8'h00, 8'h00};
    send_image(-1);
    total++; if (error !== 1'b1)    begin bad++; $display("FAIL too_long.error got %b want 1", error); end
    total++; if (core_rst !== 1'b0) begin bad++; $display("FAIL too_long.core_rst got %b want 0", core_rst); end
    total++; if (done !== 1'b0)     begin bad++; $display("FAIL too_long.done got %b want 0", done); end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL too_long.count got %0d want 0", got_q.size()); end
  endtask

  task automatic test_framing();
    do_reset();
    img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h31, 8'h00};
    send_image(1);
    total++; if (error !== 1'b1)    begin bad++; $display("FAIL framing.error got %b want 1", error); end
    total++; if (done !== 1'b0)     begin bad++; $display("FAIL framing.done got %b want 0", done); end
    total++; if (core_rst !== 1'b0) begin bad++; $display("FAIL framing.core_rst got %b want 0", core_rst); end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL framing.count got %0d want 0", got_q.size()); end
  endtask

  task automatic test_glitch();
    do_reset();
    @(negedge clk); rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    img = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    add_chk();
    send_image(-1);
    total++; if (got_q.size() != 1) begin bad++; $display("FAIL glitch.count got %0d want 1", got_q.size()); end
    total++;
    if (got_q.size() < 1) begin bad++; $display("FAIL glitch.word got none want 00deadbeef"); end
    else if (got_q[0] !== {8'h00, 32'hDEAD_BEEF}) begin bad++; $display("FAIL glitch.word got %h want 00deadbeef", got_q[0]); end
    total++; if (done !== 1'b1)  begin bad++; $display("FAIL glitch.done got %b want 1", done); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL glitch.error got %b want 0", error); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w;
    do_reset();
    img = '{8'h01, 8'h00, 8'hEF, 8'hBE};
    send_image(-1);
    @(posedge clk); #3 rst = 1'b0;
    #1;
    total++; if (en !== 1'b0 || done !== 1'b0 || error !== 1'b0 || core_rst !== 1'b0 || instruction !== 32'h0)
      begin bad++; $display("FAIL reset_mid.a_outputs got en=%b done=%b err=%b crst=%b ins=%h want all 0", en, done, error, core_rst, instruction); end
    repeat (3) @(negedge clk);
    got_q.delete(); rst = 1'b1;
    repeat (3) @(negedge clk);
    img = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};
    send_image(-1);
    total++; if (got_q.size() != 2) begin bad++; $display("FAIL reset_mid.b_count got %0d want 2", got_q.size()); end
    @(posedge clk); #3 rst = 1'b0;
    #1;
    total++; if (instruction !== 32'h0) begin bad++; $display("FAIL reset_mid.b_instruction got %h want 0", instruction); end
    total++; if (addr !== '0)           begin bad++; $display("FAIL reset_mid.b_addr got %h want 0", addr); end
    repeat (3) @(negedge clk);
    got_q.delete(); rst = 1'b1;
    repeat (3) @(negedge clk);
    w = $urandom;
    img = '{8'h01, 8'h00, w[7:0], w[15:8], w[23:16], w[31:24]};
    add_chk();
    send_image(-1);
    total++;
    if (got_q.size() != 1) begin bad++; $display("FAIL reset_mid.reload_count got %0d want 1", got_q.size()); end
    else if (got_q[0] !== {8'h00, w}) begin bad++; $display("FAIL reset_mid.reload_word got %h want %h", got_q[0], {8'h00, w}); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL reset_mid.reload_done got %b want 1", done); end
  endtask

  task automatic test_random();
    int n, nb, bad_idx;
    for (int iter = 0; iter < 8; iter++) begin
      do_reset();
      img.delete();
      n = $urandom_range(1, 6);
      if (iter == 3) n = int'(DEPTH) + 1 + int'($urandom_range(0, 300));
      nb = (n > int'(DEPTH)) ? 4 : 4 * n;
      img.push_back(8'(n));
      img.push_back(8'(n >> 8));
      for (int i = 0; i < nb; i++) img.push_back(8'($urandom));
      add_chk();
`ifdef LOADER_CHECKSUM_EN
      if (iter == 6) img[img.size() - 1] = img[img.size() - 1] ^ 8'h5A;
`endif
      bad_idx = (iter == 5) ? int'($urandom_range(0, img.size() - 1)) : -1;
      model(bad_idx);
      send_image(bad_idx);
      total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL random%0d.count got %0d want %0d", iter, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (i >= got_q.size()) begin bad++; $display("FAIL random%0d.w%0d got none want %h", iter, i, exp_q[i]); end
        else if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL random%0d.w%0d got %h want %h", iter, i, got_q[i], exp_q[i]); end
      end
      total++; if (done !== exp_done)     begin bad++; $display("FAIL random%0d.done got %b want %b", iter, done, exp_done); end
      total++; if (error !== exp_err)     begin bad++; $display("FAIL random%0d.error got %b want %b", iter, error, exp_err); end
      total++; if (core_rst !== exp_done) begin bad++; $display("FAIL random%0d.core_rst got %b want %b", iter, core_rst, exp_done); end
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    img = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    send_image(-1);
    total++; if (done !== 1'b1)     begin bad++; $display("FAIL checksum.good_done got %b want 1", done); end
    total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL checksum.good_core_rst got %b want 1", core_rst); end
    do_reset();
    img = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    send_image(-1);
    total++; if (got_q.size() != 1) begin bad++; $display("FAIL checksum.bad_count got %0d want 1", got_q.size()); end
    total++; if (error !== 1'b1)    begin bad++; $display("FAIL checksum.bad_error got %b want 1", error); end
    total++; if (core_rst !== 1'b0) begin bad++; $display("FAIL checksum.bad_core_rst got %b want 0", core_rst); end
    total++; if (done !== 1'b0)     begin bad++; $display("FAIL checksum.bad_done got %b want 0", done); end
  endtask
`endif

  initial begin
    test_reset();
    test_two_words();
    test_zero_len();
    test_too_long();
    test_framing();
    test_glitch();
    test_reset_mid();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
